// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the instruction-fetch stage: next-PC selects, FSM states and
// default reset/exception vectors.
package fetch_unit_pkg;

    // NPCOp codes driven by the control decoder.
    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_EXCEPT = 3'b011;

    localparam logic [31:0] DefaultResetPc = 32'h0000_3000;
    localparam logic [31:0] DefaultExcVec  = 32'h0000_4180;

    typedef enum logic [1:0] {
        FsIdle  = 2'b00,
        FsFetch = 2'b01,
        FsExec  = 2'b10,
        FsHalt  = 2'b11
    } fetch_state_e;

    // Branch displacement: sign-extended word offset turned into a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_npc.sv
// Combinational next-PC selection for the fetch stage.
module fetch_npc
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = DefaultExcVec
) (
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [2:0]  npc_op,
    output logic [31:0] next_pc,
    output logic        is_exc
);

    logic [31:0] pc_plus4;
    logic        unused_opcode;

    assign pc_plus4      = pc + 32'd4;
    // Opcode/funct live in the decoder; only the immediate and jump index matter here.
    assign unused_opcode = ^instr[31:26];

    always_comb begin
        next_pc = pc_plus4;
        is_exc  = 1'b0;
        case (npc_op)
            NPC_PLUS4:  next_pc = pc_plus4;
            NPC_BRANCH: next_pc = pc_plus4 + branch_offset(instr[15:0]);
            NPC_JUMP:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            NPC_EXCEPT: begin
                next_pc = EXC_VEC;
                is_exc  = 1'b1;
            end
            // Reserved codes 4..7 redirect like an exception.
            default: begin
                next_pc = EXC_VEC;
                is_exc  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC/IR/EPC, runs the req/ack handshake to instruction
// memory and commits the next PC chosen by the decoder's NPCOp.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc,
    parameter logic [31:0] EXC_VEC  = DefaultExcVec
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  npc_op,
    input  logic        hold,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic        im_ack,
    input  logic        im_err,
    output logic [31:0] instr,
    output logic        nop,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic        halted
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  epc_q, epc_d;
    logic [31:0]  next_pc;
    logic         npc_exc;

    fetch_npc #(
        .EXC_VEC (EXC_VEC)
    ) u_npc (
        .pc      (pc_q),
        .instr   (instr_q),
        .npc_op  (npc_op),
        .next_pc (next_pc),
        .is_exc  (npc_exc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FsIdle;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            epc_q   <= epc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        epc_d   = epc_q;
        im_req  = 1'b0;
        nop     = 1'b1;
        halted  = 1'b0;

        unique case (state_q)
            // Acks seen here belong to a request aborted by reset and are dropped.
            FsIdle: state_d = FsFetch;

            FsFetch: begin
                im_req = 1'b1;
                if (im_ack) begin
                    if (!im_err) begin
                        instr_d = im_rdata;
                        state_d = FsExec;
                    end else if (pc_q != EXC_VEC) begin
                        // Retry at the vector without dropping the request.
                        epc_d = pc_q;
                        pc_d  = EXC_VEC;
                    end else begin
                        state_d = FsHalt;
                    end
                end
            end

            FsExec: begin
                nop = 1'b0;
                if (!hold) begin
                    pc_d    = next_pc;
                    state_d = FsFetch;
                    if (npc_exc) begin
                        epc_d = pc_q;
                    end
                end
            end

            FsHalt: halted = 1'b1;
        endcase
    end

    assign im_addr  = pc_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign instr    = instr_q;
    assign epc      = epc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, hand-written corner sequences and a
// randomized run against a behavioural PC model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst, hold, im_ack, im_err;
    logic [2:0]  npc_op;
    logic [31:0] im_rdata;
    logic        im_req, nop, halted;
    logic [31:0] im_addr, instr, pc, pc_plus4, epc;

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] m_pc, m_epc, m_instr, exp_pc, nxt, p4, word;
    logic [2:0]  op;
    int          off, lat, hc;

    typedef struct {
        logic [31:0] word;
        logic [2:0]  op;
        int          lat;
        int          hold_cyc;
        logic [31:0] next;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl[20];

    fetch_unit #(
        .RESET_PC (RST_PC),
        .EXC_VEC  (EXC_PC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .npc_op   (npc_op),
        .hold     (hold),
        .im_req   (im_req),
        .im_addr  (im_addr),
        .im_rdata (im_rdata),
        .im_ack   (im_ack),
        .im_err   (im_err),
        .instr    (instr),
        .nop      (nop),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .epc      (epc),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        im_ack   = 1'b0;
        im_err   = 1'b0;
        hold     = 1'b0;
        npc_op   = NPC_PLUS4;
        im_rdata = '0;
        step();
        step();
        rst     = 1'b0;
        m_instr = '0;
    endtask

    task automatic reset_checks();
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_nop", 32'(nop), 32'd1);
        chk("rst_req", 32'(im_req), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (im_req !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk({name, "_req_seen"}, 32'(im_req), 32'd1);
    endtask

    // Fetch one word at exp_pc after lat wait cycles, then execute it with op after hc
    // hold cycles. Returns with the DUT in the following fetch.
    task automatic run_instr(input string name, input logic [31:0] at_pc, input logic [31:0] w,
                             input int lat_c, input int hold_c, input logic [2:0] code);
        wait_req(name);
        chk({name, "_addr"}, im_addr, at_pc);
        for (int i = 0; i < lat_c; i++) begin
            im_ack = 1'b0;
            step();
            chk({name, "_wait_req"}, 32'(im_req), 32'd1);
            chk({name, "_wait_addr"}, im_addr, at_pc);
            chk({name, "_wait_nop"}, 32'(nop), 32'd1);
            chk({name, "_wait_instr"}, instr, m_instr);
        end
        im_ack   = 1'b1;
        im_err   = 1'b0;
        im_rdata = w;
        step();
        im_ack   = 1'b0;
        im_rdata = '0;
        m_instr  = w;
        chk({name, "_instr"}, instr, w);
        chk({name, "_nop"}, 32'(nop), 32'd0);
        chk({name, "_pc"}, pc, at_pc);
        chk({name, "_pc4"}, pc_plus4, at_pc + 32'd4);
        chk({name, "_exec_req"}, 32'(im_req), 32'd0);
        for (int i = 0; i < hold_c; i++) begin
            hold   = 1'b1;
            npc_op = 3'($urandom);
            step();
            chk({name, "_hold_pc"}, pc, at_pc);
            chk({name, "_hold_instr"}, instr, w);
            chk({name, "_hold_nop"}, 32'(nop), 32'd0);
        end
        hold   = 1'b0;
        npc_op = code;
        step();
        npc_op = NPC_PLUS4;
    endtask

    initial begin
        tbl[0]  = '{32'h2008_0005, NPC_PLUS4,  0, 0, 32'h0000_3004, 32'h0000_0000};
        tbl[1]  = '{32'h0000_0000, NPC_PLUS4,  3, 0, 32'h0000_3008, 32'h0000_0000};
        tbl[2]  = '{32'h0000_0000, NPC_PLUS4,  1, 0, 32'h0000_300C, 32'h0000_0000};
        tbl[3]  = '{32'h0000_0000, NPC_PLUS4,  0, 0, 32'h0000_3010, 32'h0000_0000};
        tbl[4]  = '{32'h1000_FFFC, NPC_BRANCH, 0, 0, 32'h0000_3004, 32'h0000_0000};
        tbl[5]  = '{32'h0000_0000, NPC_PLUS4,  0, 0, 32'h0000_3008, 32'h0000_0000};
        tbl[6]  = '{32'h0000_0000, 3'b011,     0, 0, 32'h0000_4180, 32'h0000_3008};
        tbl[7]  = '{32'h0000_0000, 3'b111,     0, 0, 32'h0000_4180, 32'h0000_4180};
        tbl[8]  = '{32'h0800_0C02, NPC_JUMP,   0, 0, 32'h0000_3008, 32'h0000_4180};
        tbl[9]  = '{32'h0000_0000, 3'b110,     0, 0, 32'h0000_4180, 32'h0000_3008};
        tbl[10] = '{32'h0800_0C04, NPC_JUMP,   0, 0, 32'h0000_3010, 32'h0000_3008};
        tbl[11] = '{32'h1000_0002, NPC_BRANCH, 2, 0, 32'h0000_301C, 32'h0000_3008};
        tbl[12] = '{32'h0000_0000, NPC_PLUS4,  0, 0, 32'h0000_3020, 32'h0000_3008};
        tbl[13] = '{32'h0800_0C00, NPC_JUMP,   0, 2, 32'h0000_3000, 32'h0000_3008};
        tbl[14] = '{32'h0000_0000, 3'b100,     0, 0, 32'h0000_4180, 32'h0000_3000};
        tbl[15] = '{32'h0000_0000, 3'b101,     0, 1, 32'h0000_4180, 32'h0000_4180};
        tbl[16] = '{32'h0800_0C00, NPC_JUMP,   0, 0, 32'h0000_3000, 32'h0000_4180};
        tbl[17] = '{32'h1000_F3FE, NPC_BRANCH, 0, 0, 32'hFFFF_FFFC, 32'h0000_4180};
        tbl[18] = '{32'h0000_0000, NPC_PLUS4,  0, 0, 32'h0000_0000, 32'h0000_4180};
        tbl[19] = '{32'h0800_0C00, NPC_JUMP,   1, 0, 32'h0000_3000, 32'h0000_4180};

        // Reset and first-request timing.
        do_reset();
        reset_checks();
        step();
        chk("first_req", 32'(im_req), 32'd1);
        chk("first_addr", im_addr, RST_PC);

        exp_pc = RST_PC;
        for (int i = 0; i < 20; i++) begin
            run_instr("vec", exp_pc, tbl[i].word, tbl[i].lat, tbl[i].hold_cyc, tbl[i].op);
            chk("vec_next_addr", im_addr, tbl[i].next);
            chk("vec_next_req", 32'(im_req), 32'd1);
            chk("vec_epc", epc, tbl[i].epc);
            exp_pc = tbl[i].next;
        end

        // Fetch bus error away from the vector, then again at the vector: double fault.
        im_ack = 1'b1;
        im_err = 1'b1;
        step();
        im_ack = 1'b0;
        im_err = 1'b0;
        chk("ferr_req", 32'(im_req), 32'd1);
        chk("ferr_addr", im_addr, EXC_PC);
        chk("ferr_epc", epc, 32'h0000_3000);
        chk("ferr_nop", 32'(nop), 32'd1);
        chk("ferr_halted", 32'(halted), 32'd0);
        im_ack = 1'b1;
        im_err = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            im_ack = 1'($urandom);
            im_err = 1'($urandom);
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_req", 32'(im_req), 32'd0);
            chk("halt_nop", 32'(nop), 32'd1);
            step();
        end
        im_ack = 1'b0;
        im_err = 1'b0;

        // Reset aborting a fetch, with a stale ack in the first idle cycle.
        do_reset();
        reset_checks();
        run_instr("pre_abort", RST_PC, 32'h2008_0005, 0, 0, NPC_PLUS4);
        chk("pre_abort_addr", im_addr, 32'h0000_3004);
        step();
        rst = 1'b1;
        step();
        rst      = 1'b0;
        im_ack   = 1'b1;
        im_rdata = 32'hDEAD_BEEF;
        chk("abort_idle_req", 32'(im_req), 32'd0);
        chk("abort_idle_pc", pc, RST_PC);
        step();
        im_ack   = 1'b0;
        im_rdata = '0;
        m_instr  = '0;
        chk("abort_instr", instr, 32'h0);
        chk("abort_pc", pc, RST_PC);
        chk("abort_req", 32'(im_req), 32'd1);
        chk("abort_nop", 32'(nop), 32'd1);
        run_instr("post_abort", RST_PC, 32'h1234_5678, 1, 0, NPC_PLUS4);
        chk("post_abort_next", im_addr, 32'h0000_3004);

        // Randomized run against the behavioural model.
        do_reset();
        m_pc  = RST_PC;
        m_epc = '0;
        for (int k = 0; k < 200; k++) begin
            word = $urandom;
            op   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7))
                                               : 3'($urandom_range(0, 2));
            lat  = $urandom_range(0, 3);
            hc   = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) begin
                wait_req("rnd_err");
                chk("rnd_err_addr", im_addr, m_pc);
                im_ack = 1'b1;
                im_err = 1'b1;
                step();
                im_ack = 1'b0;
                im_err = 1'b0;
                if (m_pc == EXC_PC) begin
                    chk("rnd_dfault", 32'(halted), 32'd1);
                    chk("rnd_dfault_req", 32'(im_req), 32'd0);
                    do_reset();
                    reset_checks();
                    m_pc  = RST_PC;
                    m_epc = '0;
                end else begin
                    m_epc = m_pc;
                    m_pc  = EXC_PC;
                    chk("rnd_ferr_addr", im_addr, m_pc);
                    chk("rnd_ferr_epc", epc, m_epc);
                end
            end else begin
                run_instr("rnd", m_pc, word, lat, hc, op);
                p4 = m_pc + 32'd4;
                case (op)
                    3'd0: nxt = p4;
                    3'd1: begin
                        off = $signed(word[15:0]);
                        nxt = p4 + 32'(off * 4);
                    end
                    3'd2: nxt = (p4 & 32'hF000_0000) | ({6'b0, word[25:0]} << 2);
                    default: begin
                        m_epc = m_pc;
                        nxt   = EXC_PC;
                    end
                endcase
                m_pc = nxt;
                chk("rnd_next_addr", im_addr, m_pc);
                chk("rnd_epc", epc, m_epc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the control decoder. It owns the PC register and runs a req/ack handshake to instruction memory. It presents the fetched word (opcode/funct/rt fields) and the nop qualifier to the decoder. It consumes the decoder's NPCOp to compute and commit the next PC, including branch, jump and exception redirects.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset.
EXC_VEC, 32'h0000_4180, PC loaded on any exception redirect.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, synchronous, active-high.
npc_op  in  3  NPCOp from decoder; valid only while nop=0.
hold  in  1  stretch execute cycle (multi-cycle datapath op); keeps current instruction.
im_req  out  1  instruction-memory request.
im_addr  out  32  word address; equals pc while im_req=1.
im_rdata  in  32  instruction word; sampled when im_ack=1.
im_ack  in  1  memory response strobe.
im_err  in  1  bus error; qualified by im_ack.
instr  out  32  current instruction register.
nop  out  1  1 = instr not valid this cycle; decoder forces all controls to 0.
pc  out  32  address of instr.
pc_plus4  out  32  pc+4, mod 2^32.
epc  out  32  PC of the last excepting instruction or fetch.
halted  out  1  double fault; stays 1 until reset.

Behaviour:
- Reset state: IDLE. pc=RESET_PC, instr=0, epc=0, nop=1, im_req=0, halted=0.
- FSM states: IDLE, FETCH, EXEC, HALT.
- IDLE: im_req=0, nop=1. Goes to FETCH next cycle unconditionally. im_ack in IDLE is ignored, which drops stale acks from a request aborted by reset.
- FETCH: im_req=1, im_addr=pc, nop=1. Waits any number of cycles for im_ack.
  - On im_ack with im_err=0: instr<=im_rdata, go to EXEC. Zero-wait ack (same cycle as first req) is legal, so min fetch latency is 1 cycle.
  - On im_ack with im_err=1 and pc!=EXC_VEC: epc<=pc, pc<=EXC_VEC, stay in FETCH. im_req drops for 0 cycles.
  - On im_ack with im_err=1 and pc==EXC_VEC: go to HALT.
- EXEC: nop=0, im_req=0, instr stable.
  - If hold=1: stay in EXEC; pc and instr unchanged.
  - Else at the edge: pc<=next_pc, go to FETCH.
- next_pc by npc_op (codes from ctrl_encode_def.v: NPC_PLUS4=3'b000, NPC_BRANCH=3'b001, NPC_JUMP=3'b010, NPC_EXCEPT=3'b011):
  - PLUS4: pc+4.
  - BRANCH: pc+4 + (sext(instr[15:0])<<2), 32-bit wrap.
  - JUMP: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - EXCEPT: EXC_VEC, and epc<=pc in the same edge.
  - Codes 4..7: treated as EXCEPT.
- HALT: nop=1, im_req=0, halted=1. Only rst exits.
- Branch Zero qualification is the decoder's job; this block trusts npc_op.
- rst has priority over every event in every state. An aborted fetch leaves no side effects.
- pc+4 at 32'hFFFF_FFFC wraps to 0 with no exception.

Decomposition:
- Shared header ctrl_encode_def.v gets the NPC_* codes, FSM state encodings (FS_IDLE..FS_HALT, 2 bits), and default RESET_PC/EXC_VEC macros.
- Sub-module fetch_npc: combinational next-PC mux (inputs pc, instr, npc_op; outputs next_pc, is_exc).
- FSM, PC/IR/EPC registers and handshake stay in fetch_unit.

Test Plan:
- Reset, then zero-wait memory returning 32'h2008_0005 -> im_req at cycle 2, addr 32'h3000. Next cycle instr=32'h2008_0005, nop=0. With NPC_PLUS4, the next fetch addr is 32'h3004.
- 3-cycle ack latency -> im_req held with addr constant for 3 cycles; nop=1 throughout; instr loads only on the ack cycle.
- pc=32'h3010, instr=beq with imm 16'hFFFC, npc_op=BRANCH -> next fetch addr 32'h3004. With imm 16'h0002 -> 32'h301C.
- pc=32'h3020, instr=32'h0800_0C00, npc_op=JUMP -> next addr 32'h0000_3000. hold=1 for 2 cycles first -> pc and instr unchanged, nop=0 throughout.
- npc_op=3'b011 and separately 3'b110 at pc=32'h3008 -> epc=32'h3008, next addr 32'h4180. Then im_err on that fetch -> halted=1, im_req=0 permanently until rst.
- rst asserted mid-FETCH, with ack arriving in the first post-reset IDLE cycle -> ack ignored, instr stays 0, pc=32'h3000, FETCH restarts cleanly.
